// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding, word-addressed 32-bit data memory
// responder with a request/response handshake and byte-lane stores.
// Optional macro DMEM_WAIT_EN: when defined, WAIT_CYCLES wait states are
// counted before the memory access; when undefined the counter is absent and
// the access happens one edge after the request is accepted.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;
`ifdef DMEM_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
    // Wait states are compiled out; the parameter is accepted but has no effect.
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    // S_WAIT is the pre-access stage: it counts down the wait states (if any)
    // and its final edge performs the access and enters S_RESP.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
`ifdef DMEM_WAIT_EN
    logic [CW-1:0]         cnt_q;
`endif
    logic [31:0]           mem_q [0:WORDS-1];

    logic [DEPTH_LOG2-1:0] idx_d;
    logic                  err_d;
    logic                  done_d;
    logic                  access_d;
    logic                  mem_we_d;
    logic [31:0]           rdata_d;
    logic [31:0]           wword_d;

    // Decode the latched request: index, error, access strobe, load data and merged store word.
    always_comb begin
        idx_d = addr_q[DEPTH_LOG2+1:2];
        err_d = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
`ifdef DMEM_WAIT_EN
        done_d = (cnt_q == {CW{1'b0}});
`else
        done_d = 1'b1;
`endif
        // rst gates the access so a store dropped by reset never reaches storage.
        if ((state_q == S_WAIT) && done_d && !rst) begin
            access_d = 1'b1;
        end else begin
            access_d = 1'b0;
        end
        if (access_d && write_q && !err_d) begin
            mem_we_d = 1'b1;
        end else begin
            mem_we_d = 1'b0;
        end
        if (!write_q && !err_d) begin
            rdata_d = mem_q[idx_d];
        end else begin
            rdata_d = 32'd0;
        end
        wword_d = mem_q[idx_d];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                wword_d[8*i +: 8] = wdata_q[8*i +: 8];
            end else begin
                wword_d[8*i +: 8] = mem_q[idx_d][8*i +: 8];
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
`ifdef DMEM_WAIT_EN
            cnt_q      <= {CW{1'b0}};
`endif
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        state_q   <= S_WAIT;
`ifdef DMEM_WAIT_EN
                        cnt_q     <= CW'(WAIT_CYCLES);
`endif
                    end
                end
                S_WAIT: begin
                    if (done_d) begin
                        state_q    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_d;
                        resp_err   <= err_d;
                    end
`ifdef DMEM_WAIT_EN
                    else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    // Response held stable until accepted; the accepting edge
                    // only returns to idle, it never takes a new request.
                    if (resp_ready) begin
                        state_q    <= S_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port; intentionally has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[idx_d] <= wword_d;
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, SHALL set word-addressed storage depth to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set wait states inserted before each response when DMEM_WAIT_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address; word index = req_addr[DEPTH_LOG2+1:2].
REQ-008 req_wdata  input  32  store data.
REQ-009 req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Request accepted on a rising edge where req_valid && req_ready; write, addr, wdata, be SHALL be latched then; later input changes ignored.
REQ-017 On accept: go to WAIT loaded with WAIT_CYCLES if DMEM_WAIT_EN defined and WAIT_CYCLES > 0; else go directly to RESP.
REQ-018 WAIT SHALL decrement its counter once per cycle and enter RESP on the edge where the counter reaches 0; total latency accept edge to resp_valid = WAIT_CYCLES+1 edges.
REQ-019 The memory access (store update or load capture) SHALL occur on the edge entering RESP, never earlier.
REQ-020 Error when latched addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0: resp_err=1, resp_rdata=0, storage unchanged.
REQ-021 Store: only enabled byte lanes written; be=0000 SHALL be a legal no-op returning resp_err=0.
REQ-022 Load: resp_rdata SHALL equal full 32-bit word at the index, including any store completed in the immediately preceding transaction.
REQ-023 In RESP, resp_valid, resp_rdata, resp_err SHALL hold stable until a rising edge with resp_ready=1, then return to IDLE; no new request accepted on that same edge.
REQ-024 resp_ready asserted while not in RESP SHALL be ignored.
REQ-025 Exactly one outstanding transaction; back-to-back throughput SHALL be one transaction per WAIT_CYCLES+3 cycles maximum (with macro), 3 cycles without.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, wait counter 0, req_ready=1 (once rst low), resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 Reset during WAIT SHALL drop the transaction; a pending store SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_WAIT_EN: defined -> WAIT state and counter present, latency WAIT_CYCLES+1; undefined -> no WAIT state or counter logic, latency 1 edge, WAIT_CYCLES ignored.

Verification
REQ-030 Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-031 Word 0x10 = 0xDEADBEEF; store be=0010, wdata=0x0000AA00; load -> 0xDEADAABE... corrected: 0xDEADAAEF.
REQ-032 Load addr=0x13 -> resp_err=1, resp_rdata=0; load addr=0x400 (DEPTH_LOG2=8) -> resp_err=1; storage unchanged.
REQ-033 DMEM_WAIT_EN, WAIT_CYCLES=2: accept at edge N -> resp_valid first high after edge N+3; undefined -> after edge N+1.
REQ-034 Hold resp_ready=0 five cycles in RESP -> resp_valid, resp_rdata, resp_err constant, req_ready=0 throughout.
REQ-035 Store 0x55555555 to 0x20, assert rst during WAIT -> outputs reset at once; subsequent load 0x20 returns prior contents.
